// File: rtl/controle_frota_pkg.sv
// +--------------------------------------------------------------------------+
// | controle_frota_pkg: fleet controller states, direction codes, period fn  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package controle_frota_pkg;

  typedef enum logic [2:0] {
    ST_ESPERA  = 3'd0,
    ST_VARRE   = 3'd1,
    ST_DECIDE  = 3'd2,
    ST_ASSENTA = 3'd3,
    ST_PULSO   = 3'd4,
    ST_PARADO  = 3'd5
  } estado_t;

  localparam logic SENTIDO_DIR = 1'b1;
  localparam logic SENTIDO_ESQ = 1'b0;

  // Wait length shrinks per dead enemy, clamped at the floor without underflow.
  function automatic logic [31:0] calc_periodo(input logic [31:0] base,
                                               input logic [31:0] passo,
                                               input logic [31:0] piso,
                                               input logic [31:0] mortos);
    logic [63:0] reducao;
    reducao = 64'(mortos) * 64'(passo);
    if (reducao >= 64'(base)) return piso;
    else if ((base - reducao[31:0]) < piso) return piso;
    else return base - reducao[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/controle_frota_divisor_movimento.sv
// +--------------------------------------------------------------------------+
// | controle_frota_divisor_movimento: programmable period counter -> fim    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module controle_frota_divisor_movimento (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] periodo,
  output logic        fim
);

  logic [31:0] contador;

  assign fim = enable && (contador >= (periodo - 32'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contador <= '0;
    end else if (clear || fim) begin
      contador <= '0;
    end else if (enable) begin
      contador <= contador + 32'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/controle_frota.sv
// +--------------------------------------------------------------------------+
// | controle_frota: enemy fleet move clock, direction, kill/invasion status |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module controle_frota
  import controle_frota_pkg::*;
#(
  parameter int N_INIMIGOS      = 8,
  parameter int LARGURA         = 33,
  parameter int ALTURA          = 24,
  parameter int PASSO           = 2,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 640,
  parameter int Y_INVASAO       = 440,
  parameter int DIV_BASE        = 2_000_000,
  parameter int DIV_STEP        = 200_000,
  parameter int DIV_MIN         = 200_000,
  parameter int PULSO           = 4,
  parameter int SENTIDO_INICIAL = 1
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    pausa,
  input  logic                    reiniciarJogo,
  input  logic [10*N_INIMIGOS-1:0] xs,
  input  logic [10*N_INIMIGOS-1:0] ys,
  input  logic [N_INIMIGOS-1:0]   vivos,
  output logic                    CLOCK_MV,
  output logic                    sentidoX,
  output logic [3:0]              n_vivos,
  output logic                    onda_vencida,
  output logic                    invasao
);

  localparam int         IDX_W         = (N_INIMIGOS > 1) ? $clog2(N_INIMIGOS) : 1;
  localparam logic       SENTIDO_RESET = 1'(SENTIDO_INICIAL);
  localparam logic [3:0] N_RESET       = 4'(N_INIMIGOS);

  estado_t          estado, prox;
  logic [IDX_W-1:0] idx;
  logic [10:0]      acc_xmin, acc_xmax;
  logic [3:0]       acc_cont;
  logic             acc_inv;
  logic [31:0]      cont_pulso;
  logic [31:0]      periodo;
  logic             fim_espera;
  logic [9:0]       xa [N_INIMIGOS];
  logic [9:0]       ya [N_INIMIGOS];
  logic [10:0]      x_esq, x_dir, y_base;

  for (genvar g = 0; g < N_INIMIGOS; g++) begin : g_desempacota
    assign xa[g] = xs[10*g +: 10];
    assign ya[g] = ys[10*g +: 10];
  end

  assign x_esq  = {1'b0, xa[idx]};
  assign x_dir  = {1'b0, xa[idx]} + 11'(LARGURA);
  assign y_base = {1'b0, ya[idx]} + 11'(ALTURA);

  assign periodo = calc_periodo(32'(DIV_BASE), 32'(DIV_STEP), 32'(DIV_MIN),
                                32'(N_INIMIGOS) - 32'(n_vivos));

  controle_frota_divisor_movimento u_divisor (
    .clk     (CLOCK_50),
    .rst     (reset),
    .clear   (reiniciarJogo || (estado != ST_ESPERA)),
    .enable  ((estado == ST_ESPERA) && !pausa && !reiniciarJogo),
    .periodo (periodo),
    .fim     (fim_espera)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) estado <= ST_ESPERA;
    else       estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      ST_ESPERA:  if (fim_espera) prox = ST_VARRE;
      ST_VARRE:   if (idx == IDX_W'(N_INIMIGOS - 1)) prox = ST_DECIDE;
      ST_DECIDE:  prox = ((acc_cont == 4'd0) || acc_inv) ? ST_PARADO : ST_ASSENTA;
      ST_ASSENTA: prox = ST_PULSO;
      ST_PULSO:   if (cont_pulso >= 32'(PULSO - 1)) prox = ST_ESPERA;
      ST_PARADO:  prox = ST_PARADO;
      default:    prox = ST_ESPERA;
    endcase
    if (reiniciarJogo) prox = ST_ESPERA;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      CLOCK_MV     <= 1'b0;
      sentidoX     <= SENTIDO_RESET;
      n_vivos      <= N_RESET;
      onda_vencida <= 1'b0;
      invasao      <= 1'b0;
      idx          <= '0;
      acc_xmin     <= '1;
      acc_xmax     <= '0;
      acc_cont     <= '0;
      acc_inv      <= 1'b0;
      cont_pulso   <= '0;
    end else if (reiniciarJogo) begin
      CLOCK_MV     <= 1'b0;
      sentidoX     <= SENTIDO_RESET;
      n_vivos      <= N_RESET;
      onda_vencida <= 1'b0;
      invasao      <= 1'b0;
      idx          <= '0;
      cont_pulso   <= '0;
    end else begin
      CLOCK_MV <= (prox == ST_PULSO);
      case (estado)
        ST_ESPERA: begin
          if (fim_espera) begin
            idx      <= '0;
            acc_xmin <= '1;
            acc_xmax <= '0;
            acc_cont <= '0;
            acc_inv  <= 1'b0;
          end
        end
        ST_VARRE: begin
          if (vivos[idx]) begin
            acc_cont <= acc_cont + 4'd1;
            if (x_esq < acc_xmin) acc_xmin <= x_esq;
            if (x_dir > acc_xmax) acc_xmax <= x_dir;
            if (y_base >= 11'(Y_INVASAO)) acc_inv <= 1'b1;
          end
          idx <= idx + IDX_W'(1);
        end
        ST_DECIDE: begin
          n_vivos <= acc_cont;
          if (acc_cont == 4'd0) onda_vencida <= 1'b1;
          if (acc_inv) invasao <= 1'b1;
          // Only the edge we are heading towards can trigger a turn.
          if ((acc_cont != 4'd0) && !acc_inv) begin
            if ((sentidoX == SENTIDO_DIR) && ((acc_xmax + 11'(PASSO)) > 11'(X_MAX)))
              sentidoX <= SENTIDO_ESQ;
            else if ((sentidoX == SENTIDO_ESQ) && (acc_xmin < 11'(X_MIN + PASSO)))
              sentidoX <= SENTIDO_DIR;
          end
        end
        ST_ASSENTA: cont_pulso <= '0;
        ST_PULSO:   cont_pulso <= cont_pulso + 32'd1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
